// File: rtl/dp_pkg.sv
// Shared constants for the 16-bit datapath: sequencer states, opcode/function
// fields and register-file write-destination codes.
package dp_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StWait   = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6,
    StError  = 3'd7
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_HALT  = 4'hF;
  localparam logic [3:0] FN_MUL   = 4'h4;
  localparam logic [3:0] FN_DIV   = 4'h5;

  localparam logic [1:0] WD_NONE   = 2'b00;
  localparam logic [1:0] WD_RD     = 2'b01;
  localparam logic [1:0] WD_RD_R15 = 2'b10;
  localparam logic [1:0] WD_RSVD   = 2'b11;

  // Ops that run on the iterative multiply/divide unit and need the ALU handshake.
  function automatic logic is_multicycle(input logic [3:0] op, input logic [3:0] fn);
    return (op == OP_RTYPE) && ((fn == FN_MUL) || (fn == FN_DIV));
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// Clearable up-counter that flags when it holds TIMEOUT-1; bounds how long the
// sequencer waits on the multi-cycle ALU.
module timeout_counter #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  localparam logic [7:0] TermVal = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == TermVal);

endmodule

// File: rtl/datapath_sequencer.sv
// Fetch/decode/execute/write-back controller for the 16-bit datapath; gates PC
// updates and register writes and handshakes with the multi-cycle ALU.
module datapath_sequencer
  import dp_pkg::*;
#(
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             CLOCK,
  input  logic             CLEAR,
  input  logic             START,
  input  logic [3:0]       OPCODE,
  input  logic [3:0]       FUNC,
  input  logic [1:0]       WRITEDST_IN,
  input  logic             ALU_DONE,
  output logic             PC_EN,
  output logic             IR_LOAD,
  output logic             ALU_START,
  output logic [1:0]       WRITEDST,
  output logic             HALTED,
  output logic             ERROR,
  output logic [2:0]       STATE,
  output logic [CNT_W-1:0] RETIRED
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             tmo_clr, tmo_en, tmo_term;

  timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i (CLOCK),
    .rst_i (CLEAR),
    .clr_i (tmo_clr),
    .en_i  (tmo_en),
    .term_o(tmo_term)
  );

  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    ALU_START = 1'b0;
    WRITEDST  = WD_NONE;
    tmo_clr   = 1'b0;
    tmo_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (START) state_d = StFetch;
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        if (OPCODE == OP_HALT) begin
          state_d = StHalt;
        end else if (is_multicycle(OPCODE, FUNC)) begin
          state_d   = StWait;
          ALU_START = 1'b1;
          tmo_clr   = 1'b1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: state_d = StWb;
      StWait: begin
        tmo_en = 1'b1;
        // A result arriving on the last allowed cycle still wins over the timeout.
        if (ALU_DONE) begin
          state_d = StWb;
        end else if (tmo_term) begin
          state_d = StError;
        end
      end
      StWb: begin
        WRITEDST  = (WRITEDST_IN == WD_RSVD) ? WD_NONE : WRITEDST_IN;
        retired_d = retired_q + CNT_W'(1);
        state_d   = StFetch;
      end
      StHalt:  state_d = StHalt;
      StError: state_d = StError;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (CLEAR) begin
      state_q   <= StIdle;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign PC_EN   = (state_q == StWb);
  assign IR_LOAD = (state_q == StFetch);
  assign HALTED  = (state_q == StHalt);
  assign ERROR   = (state_q == StError);
  assign STATE   = state_q;
  assign RETIRED = retired_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: reset, single/multi-cycle ops, timeout,
// halt, mid-WAIT clear, DONE-vs-timeout tie and retired-counter wrap.
module tb_datapath_sequencer;
  import dp_pkg::*;

  logic        CLOCK = 1'b0;
  logic        CLEAR, START, ALU_DONE, clear_w;
  logic [3:0]  OPCODE, FUNC;
  logic [1:0]  WRITEDST_IN;

  logic        PC_EN, IR_LOAD, ALU_START, HALTED, ERROR;
  logic [1:0]  WRITEDST;
  logic [2:0]  STATE;
  logic [15:0] RETIRED;

  logic        w_pc_en, w_ir_load, w_alu_start, w_halted, w_error;
  logic [1:0]  w_writedst;
  logic [2:0]  w_state;
  logic [1:0]  w_retired;

  logic [15:0] st, w_st;

  int checks = 0;
  int errors = 0;

  always #5 CLOCK = ~CLOCK;

  datapath_sequencer #(
    .TIMEOUT(32),
    .CNT_W  (16)
  ) dut (
    .CLOCK      (CLOCK),
    .CLEAR      (CLEAR),
    .START      (START),
    .OPCODE     (OPCODE),
    .FUNC       (FUNC),
    .WRITEDST_IN(WRITEDST_IN),
    .ALU_DONE   (ALU_DONE),
    .PC_EN      (PC_EN),
    .IR_LOAD    (IR_LOAD),
    .ALU_START  (ALU_START),
    .WRITEDST   (WRITEDST),
    .HALTED     (HALTED),
    .ERROR      (ERROR),
    .STATE      (STATE),
    .RETIRED    (RETIRED)
  );

  // Narrow counter and minimum timeout to reach the wrap and TIMEOUT=2 corners quickly.
  datapath_sequencer #(
    .TIMEOUT(2),
    .CNT_W  (2)
  ) u_wrap (
    .CLOCK      (CLOCK),
    .CLEAR      (clear_w),
    .START      (START),
    .OPCODE     (OPCODE),
    .FUNC       (FUNC),
    .WRITEDST_IN(WRITEDST_IN),
    .ALU_DONE   (ALU_DONE),
    .PC_EN      (w_pc_en),
    .IR_LOAD    (w_ir_load),
    .ALU_START  (w_alu_start),
    .WRITEDST   (w_writedst),
    .HALTED     (w_halted),
    .ERROR      (w_error),
    .STATE      (w_state),
    .RETIRED    (w_retired)
  );

  assign st   = {6'd0, STATE, PC_EN, IR_LOAD, ALU_START, WRITEDST, HALTED, ERROR};
  assign w_st = {6'd0, w_state, w_pc_en, w_ir_load, w_alu_start, w_writedst, w_halted, w_error};

  function automatic logic [15:0] exp_st(input logic [2:0] s, input logic pc, input logic ir,
                                         input logic as, input logic [1:0] wd, input logic h,
                                         input logic e);
    return {6'd0, s, pc, ir, as, wd, h, e};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic do_clear();
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
  endtask

  task automatic begin_run();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Entered in FETCH; leaves the sequencer in the next FETCH.
  task automatic run_op(input logic [1:0] wd_exp, input logic [15:0] ret_exp);
    chk("op_fetch", st, exp_st(StFetch, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0));
    tick();
    chk("op_decode", st, exp_st(StDecode, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
    tick();
    chk("op_exec", st, exp_st(StExec, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
    tick();
    chk("op_wb", st, exp_st(StWb, 1'b1, 1'b0, 1'b0, wd_exp, 1'b0, 1'b0));
    tick();
    chk("op_retired", RETIRED, ret_exp);
  endtask

  initial begin
    CLEAR = 1'b1; START = 1'b0; ALU_DONE = 1'b0; clear_w = 1'b1;
    OPCODE = 4'h0; FUNC = 4'h0; WRITEDST_IN = 2'b01;

    // Reset and idle
    tick();
    tick();
    CLEAR = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_state", st, exp_st(StIdle, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
      chk("idle_retired", RETIRED, 16'd0);
    end

    // Three single-cycle ops
    begin_run();
    run_op(2'b01, 16'd1);
    run_op(2'b01, 16'd2);
    run_op(2'b01, 16'd3);

    // Multiply with ALU_DONE on the 6th WAIT cycle
    do_clear();
    FUNC = 4'h4; WRITEDST_IN = 2'b10;
    begin_run();
    tick();
    chk("mul_decode", st, exp_st(StDecode, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0));
    tick();
    chk("mul_wait1", st, exp_st(StWait, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mul_wait", st, exp_st(StWait, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
    end
    ALU_DONE = 1'b1;
    tick();
    ALU_DONE = 1'b0;
    chk("mul_wb", st, exp_st(StWb, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0));
    tick();
    chk("mul_retired", RETIRED, 16'd1);

    // Divide timeout
    do_clear();
    FUNC = 4'h5; WRITEDST_IN = 2'b01;
    begin_run();
    tick();
    tick();
    for (int i = 1; i < 32; i++) begin
      chk("tmo_wait", st, exp_st(StWait, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
      tick();
    end
    chk("tmo_wait32", st, exp_st(StWait, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
    tick();
    chk("tmo_error", st, exp_st(StError, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1));
    chk("tmo_retired", RETIRED, 16'd0);
    START = 1'b1;
    tick();
    tick();
    START = 1'b0;
    chk("tmo_sticky", st, exp_st(StError, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1));
    do_clear();
    chk("tmo_cleared", st, exp_st(StIdle, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));

    // Halt after two adds
    FUNC = 4'h0; WRITEDST_IN = 2'b01;
    begin_run();
    run_op(2'b01, 16'd1);
    run_op(2'b01, 16'd2);
    OPCODE = 4'hF;
    tick();
    chk("halt_decode", st, exp_st(StDecode, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
    tick();
    chk("halt_state", st, exp_st(StHalt, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0));
    chk("halt_retired", RETIRED, 16'd2);
    for (int i = 0; i < 20; i++) begin
      START = i[0];
      tick();
      chk("halt_hold", st, exp_st(StHalt, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0));
    end
    START = 1'b0;

    // CLEAR in the middle of WAIT, with ALU_DONE also high
    do_clear();
    OPCODE = 4'h0; FUNC = 4'h0;
    begin_run();
    run_op(2'b01, 16'd1);
    FUNC = 4'h4;
    tick();
    tick();
    tick();
    tick();
    chk("clrw_wait", st, exp_st(StWait, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
    CLEAR = 1'b1; ALU_DONE = 1'b1;
    tick();
    chk("clrw_idle", st, exp_st(StIdle, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
    chk("clrw_retired", RETIRED, 16'd0);
    CLEAR = 1'b0;
    tick();
    chk("done_in_idle", st, exp_st(StIdle, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
    ALU_DONE = 1'b0;

    // ALU_DONE on the timeout cycle; reserved write-destination code 11
    do_clear();
    FUNC = 4'h5; WRITEDST_IN = 2'b11;
    begin_run();
    tick();
    tick();
    repeat (31) tick();
    chk("tie_wait32", st, exp_st(StWait, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
    ALU_DONE = 1'b1;
    tick();
    ALU_DONE = 1'b0;
    chk("tie_wb", st, exp_st(StWb, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
    tick();
    chk("tie_retired", RETIRED, 16'd1);

    // Retired-counter wrap and minimum timeout on the narrow instance
    CLEAR = 1'b1;
    FUNC = 4'h0; WRITEDST_IN = 2'b01;
    tick();
    clear_w = 1'b0;
    begin_run();
    chk("wrap_fetch", w_st, exp_st(StFetch, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      logic [1:0] e;
      e = 2'(i + 1);
      repeat (4) tick();
      chk("wrap_retired", {14'd0, w_retired}, {14'd0, e});
    end
    FUNC = 4'h5;
    tick();
    chk("t2_decode", w_st, exp_st(StDecode, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0));
    tick();
    chk("t2_wait1", w_st, exp_st(StWait, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
    tick();
    chk("t2_wait2", w_st, exp_st(StWait, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
    tick();
    chk("t2_error", w_st, exp_st(StError, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
